zmod_txrst_seq: RTL and testbench



---
 rtl/zmod_pkg.sv | 23 ++
 rtl/zmod_sync_bit.sv | 27 ++
 rtl/zmod_txrst_seq.sv | 136 +++++++++++++
 tb/tb_zmod_txrst_seq.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/zmod_pkg.sv
// Shared definitions for the zmod TX reset/enable sequencer.
//   txrst_state_t : sequencer state encoding
//   LOSS_CNT_W    : width of the saturating lock-loss counter
//   max3()        : elaboration-time helper used to size the shared counter
package zmod_pkg;

    localparam int unsigned LOSS_CNT_W = 8;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } txrst_state_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/zmod_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous status bit.
//   clk    : destination clock
//   rst    : synchronous active-high reset, clears every stage
//   data_i : asynchronous input
//   data_o : input delayed through STAGES flops (STAGES >= 2)
module zmod_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic data_i,
    output logic data_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], data_i};
        end
    end

    assign data_o = sync_q[STAGES-1];

endmodule

// File: rtl/zmod_txrst_seq.sv
// TX reset/enable sequencer fed by the TX PLL lock indicator.
//   clk        : free-running board clock
//   rst        : synchronous active-high reset
//   pll_locked : PLL lock status, asynchronous to clk
//   tx_rst     : TX datapath reset (active-high)
//   tx_en      : TX datapath enable
//   lock_lost  : one-cycle pulse when lock drops after reset release
//   loss_count : saturating count of lock_lost pulses
//   timeout    : sticky flag, PLL did not lock within LOCK_TIMEOUT cycles
module zmod_txrst_seq #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LOCK_WAIT    = 1024,
    parameter int unsigned EN_DELAY     = 16,
    parameter int unsigned LOCK_TIMEOUT = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       tx_rst,
    output logic       tx_en,
    output logic       lock_lost,
    output logic [7:0] loss_count,
    output logic       timeout
);

    import zmod_pkg::*;

    localparam int unsigned CNT_MAX = max3(LOCK_WAIT, EN_DELAY, LOCK_TIMEOUT);
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(LOCK_WAIT - 1);
    localparam logic [CNT_W-1:0] EN_LAST   = CNT_W'(EN_DELAY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);

    logic                  locked_s;
    txrst_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_count_q, loss_count_d;
    logic                  timeout_q, timeout_set;
    logic                  loss_evt;
    logic                  tx_rst_q, tx_en_q, lock_lost_q;

    zmod_sync_bit #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .data_i(pll_locked),
        .data_o(locked_s)
    );

    // Lock loss is checked before counter expiry so it always wins.
    always_comb begin
        state_d     = state_q;
        timeout_set = 1'b0;
        loss_evt    = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = STABLE;
                end else if (cnt_q == TMO_LAST && !timeout_q) begin
                    timeout_set = 1'b1;
                end
            end
            STABLE: begin
                // Drop before release is treated as a glitch, not a loss event.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == WAIT_LAST) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    loss_evt = 1'b1;
                end else if (cnt_q == EN_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d  = WAIT_LOCK;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // One shared counter; it parks at the timeout value while waiting for lock.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == WAIT_LOCK && cnt_q == TMO_LAST) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        loss_count_d = loss_count_q;
        if (loss_evt && loss_count_q != '1) begin
            loss_count_d = loss_count_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            loss_count_q <= '0;
            timeout_q    <= 1'b0;
            tx_rst_q     <= 1'b1;
            tx_en_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_count_q <= loss_count_d;
            timeout_q    <= timeout_q | timeout_set;
            // Outputs decode the next state so they move with the state register.
            tx_rst_q     <= (state_d == WAIT_LOCK) || (state_d == STABLE);
            tx_en_q      <= (state_d == RUN);
            lock_lost_q  <= loss_evt;
        end
    end

    assign tx_rst     = tx_rst_q;
    assign tx_en      = tx_en_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_zmod_txrst_seq.sv
// Directed self-checking bench for zmod_txrst_seq with small timing parameters
// (SYNC_STAGES=2, LOCK_WAIT=8, EN_DELAY=4, LOCK_TIMEOUT=50).
// Edge numbers in comments count posedges after the stated reference point.
module tb_zmod_txrst_seq;

    logic       clk;
    logic       rst;
    logic       pll_locked;
    logic       tx_rst;
    logic       tx_en;
    logic       lock_lost;
    logic [7:0] loss_count;
    logic       timeout;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    zmod_txrst_seq #(
        .SYNC_STAGES (2),
        .LOCK_WAIT   (8),
        .EN_DELAY    (4),
        .LOCK_TIMEOUT(50)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .tx_rst    (tx_rst),
        .tx_en     (tx_en),
        .lock_lost (lock_lost),
        .loss_count(loss_count),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n posedges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;

        // Test 1: lock present from the first edge after reset release.
        pll_locked = 1'b1;
        step(2);
        chk("rst_tx_rst", tx_rst, 1);
        chk("rst_tx_en", tx_en, 0);
        chk("rst_lock_lost", lock_lost, 0);
        chk("rst_loss_count", loss_count, 0);
        chk("rst_timeout", timeout, 0);
        rst = 1'b0;
        step(10);
        chk("t1_tx_rst_e10", tx_rst, 1);
        step(1);
        chk("t1_tx_rst_e11", tx_rst, 0);
        chk("t1_tx_en_e11", tx_en, 0);
        step(3);
        chk("t1_tx_en_e14", tx_en, 0);
        step(1);
        chk("t1_tx_en_e15", tx_en, 1);
        chk("t1_tx_rst_e15", tx_rst, 0);
        chk("t1_lock_lost", lock_lost, 0);
        chk("t1_timeout", timeout, 0);

        // Test 4: two-cycle glitch while in STABLE.
        rst = 1'b1;
        pll_locked = 1'b1;
        step(1);
        rst = 1'b0;
        step(5);
        pll_locked = 1'b0;
        for (int i = 6; i <= 17; i++) begin
            step(1);
            if (i == 7) pll_locked = 1'b1;
            chk("t4_tx_rst_held", tx_rst, 1);
            chk("t4_no_lock_lost", lock_lost, 0);
        end
        step(1);
        chk("t4_tx_rst_e18", tx_rst, 0);
        step(4);
        chk("t4_tx_en_e22", tx_en, 1);
        chk("t4_loss_count", loss_count, 0);

        // Test 2: no lock -> timeout at edge 50, then late lock.
        rst = 1'b1;
        pll_locked = 1'b0;
        step(1);
        rst = 1'b0;
        chk("t2_rst_timeout", timeout, 0);
        step(49);
        chk("t2_timeout_e49", timeout, 0);
        step(1);
        chk("t2_timeout_e50", timeout, 1);
        chk("t2_tx_rst_e50", tx_rst, 1);
        step(5);
        chk("t2_timeout_sticky", timeout, 1);
        chk("t2_tx_rst_held", tx_rst, 1);
        pll_locked = 1'b1;
        step(10);
        chk("t2_tx_rst_e10", tx_rst, 1);
        step(1);
        chk("t2_tx_rst_e11", tx_rst, 0);
        step(4);
        chk("t2_tx_en_e15", tx_en, 1);
        chk("t2_timeout_after_lock", timeout, 1);

        // Test 3: one-cycle drop while in RUN.
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        chk("t3_tx_rst_e2", tx_rst, 0);
        chk("t3_lock_lost_e2", lock_lost, 0);
        step(1);
        chk("t3_tx_rst_e3", tx_rst, 1);
        chk("t3_tx_en_e3", tx_en, 0);
        chk("t3_lock_lost_e3", lock_lost, 1);
        chk("t3_loss_count_e3", loss_count, 1);
        step(1);
        chk("t3_lock_lost_e4", lock_lost, 0);
        // Relock sampled at edge 2, so release lands at edge 12 and enable at 16.
        step(7);
        chk("t3_tx_rst_e11", tx_rst, 1);
        step(1);
        chk("t3_tx_rst_e12", tx_rst, 0);
        step(3);
        chk("t3_tx_en_e15", tx_en, 0);
        step(1);
        chk("t3_tx_en_e16", tx_en, 1);
        chk("t3_loss_count_final", loss_count, 1);

        // Test 5: 260 drops from RUN, loss_count starts at 1.
        for (int k = 1; k <= 260; k++) begin
            pll_locked = 1'b0;
            step(1);
            pll_locked = 1'b1;
            for (int j = 0; j < 15; j++) begin
                step(1);
                if (lock_lost === 1'b1) pulses++;
            end
            if (k == 253) chk("t5_loss_count_254", loss_count, 254);
            if (k == 254) chk("t5_loss_count_255", loss_count, 255);
        end
        chk("t5_pulses", pulses, 260);
        chk("t5_loss_count_sat", loss_count, 255);
        chk("t5_tx_en_run", tx_en, 1);

        // Test 6: reset while in RELEASE (timeout and loss_count are both set).
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(12);
        chk("t6_in_release_tx_rst", tx_rst, 0);
        chk("t6_in_release_tx_en", tx_en, 0);
        chk("t6_pre_timeout", timeout, 1);
        rst = 1'b1;
        step(1);
        chk("t6_rst_tx_rst", tx_rst, 1);
        chk("t6_rst_tx_en", tx_en, 0);
        chk("t6_rst_loss_count", loss_count, 0);
        chk("t6_rst_timeout", timeout, 0);
        rst = 1'b0;
        step(10);
        chk("t6_tx_rst_e10", tx_rst, 1);
        step(1);
        chk("t6_tx_rst_e11", tx_rst, 0);
        step(4);
        chk("t6_tx_en_e15", tx_en, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
